// File: rtl/full_adder_using_half_adder.sv
// Registered ripple-carry adder; each bit is a full adder built from two half adders and an OR.
// OUT_REG selects registered (1-cycle latency) or combinational sum/carry/overflow outputs.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_using_half_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] sum;
  logic             cout_c;
  logic             ovf_c;
  logic             valid_q;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha1 (
      .a (A[i]),
      .b (B[i]),
      .s (p[i]),
      .c (g[i])
    );
    half_adder u_ha2 (
      .a (p[i]),
      .b (c[i]),
      .s (sum[i]),
      .c (t[i])
    );
    assign c[i+1] = g[i] | t[i];
  end

  assign cout_c = c[WIDTH];
  // Carry into and out of the sign bit differ exactly on signed overflow.
  assign ovf_c  = c[WIDTH] ^ c[WIDTH-1];

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q    <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (in_valid) begin
        s_q    <= sum;
        cout_q <= cout_c;
        ovf_q  <= ovf_c;
      end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
  end else begin : g_comb
    assign S    = sum;
    assign Cout = cout_c;
    assign Ovf  = ovf_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_using_half_adder.sv
// Directed and random checks of registered and combinational adders at WIDTH=1 and WIDTH=8.

module tb_full_adder_using_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;
  logic       cin;

  logic [0:0] s1r, s1c;
  logic [7:0] s8r, s8c;
  logic       co1r, co1c, co8r, co8c;
  logic       ov1r, ov1c, ov8r, ov8c;
  logic       v1r, v1c, v8r, v8c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  full_adder_using_half_adder #(.WIDTH(1), .OUT_REG(1)) u_w1r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1), .Cin(cin),
    .S(s1r), .Cout(co1r), .Ovf(ov1r), .out_valid(v1r)
  );
  full_adder_using_half_adder #(.WIDTH(8), .OUT_REG(1)) u_w8r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8), .Cin(cin),
    .S(s8r), .Cout(co8r), .Ovf(ov8r), .out_valid(v8r)
  );
  full_adder_using_half_adder #(.WIDTH(1), .OUT_REG(0)) u_w1c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1), .Cin(cin),
    .S(s1c), .Cout(co1c), .Ovf(ov1c), .out_valid(v1c)
  );
  full_adder_using_half_adder #(.WIDTH(8), .OUT_REG(0)) u_w8c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8), .Cin(cin),
    .S(s8c), .Cout(co8c), .Ovf(ov8c), .out_valid(v8c)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_total++;
      if ({s1r, co1r, ov1r, v1r} !== 4'b0000)
        $display("FAIL reset_w1 cyc%0d: got S/Cout/Ovf/valid=%b want 0000", k,
                 {s1r, co1r, ov1r, v1r});
      else n_pass++;
      n_total++;
      if ({s8r, co8r, ov8r, v8r, v1c, v8c} !== 13'h0)
        $display("FAIL reset_w8 cyc%0d: got S=%h Cout=%b Ovf=%b valid=%b cvalid=%b%b want 0",
                 k, s8r, co8r, ov8r, v8r, v1c, v8c);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] exp_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] exp_ovf = 3'b0;
    logic [7:0] ovf_tab = 8'b0100_0010; // bit i = overflow for {A,B,Cin}=i
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, cin} = 3'(i);
      in_valid = 1'b1;
      exp_ovf[0] = ovf_tab[i];
      #1;
      n_total++;
      if ({co1c, s1c, ov1c} !== {exp_cs[i], exp_ovf[0]})
        $display("FAIL exh_comb in=%0d: got Cout,S,Ovf=%b want %b", i, {co1c, s1c, ov1c},
                 {exp_cs[i], exp_ovf[0]});
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({co1r, s1r, ov1r, v1r} !== {exp_cs[i], exp_ovf[0], 1'b1})
        $display("FAIL exh_reg in=%0d: got Cout,S,Ovf,valid=%b want %b", i,
                 {co1r, s1r, ov1r, v1r}, {exp_cs[i], exp_ovf[0], 1'b1});
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({s1r, co1r, ov1r, v1r} !== 4'b0111)
      $display("FAIL hold_load: got S,Cout,Ovf,valid=%b want 0111", {s1r, co1r, ov1r, v1r});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0; a1 = 1'(k); b1 = 1'(k + 1); cin = 1'(k);
      @(posedge clk); #1;
      n_total++;
      if ({s1r, co1r, ov1r, v1r} !== 4'b0110)
        $display("FAIL hold_cyc%0d: got S,Cout,Ovf,valid=%b want 0110", k,
                 {s1r, co1r, ov1r, v1r});
      else n_pass++;
    end
  endtask

  task automatic test_carry_w8();
    logic [7:0] va [2] = '{8'hFF, 8'h7F};
    logic [7:0] vb [2] = '{8'h00, 8'h01};
    logic       vc [2] = '{1'b1, 1'b0};
    logic [10:0] exp [2] = '{{8'h00, 1'b1, 1'b0, 1'b1}, {8'h80, 1'b0, 1'b1, 1'b1}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; cin = vc[i]; in_valid = 1'b1;
      #1;
      n_total++;
      if ({s8c, co8c, ov8c} !== exp[i][10:1])
        $display("FAIL carry_comb%0d: got S=%h Cout=%b Ovf=%b want %h", i, s8c, co8c, ov8c,
                 exp[i][10:1]);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({s8r, co8r, ov8r, v8r} !== exp[i])
        $display("FAIL carry_reg%0d: got S=%h Cout=%b Ovf=%b valid=%b want %h", i, s8r, co8r,
                 ov8r, v8r, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] va [5] = '{8'h10, 8'h80, 8'h55, 8'hF0, 8'h40};
    logic [7:0] vb [5] = '{8'h20, 8'h80, 8'h55, 8'h0F, 8'h40};
    logic       vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // {S, Cout, Ovf, out_valid}; cycle 2 is cleared by reset
    logic [10:0] exp [5] = '{{8'h30, 3'b001}, {8'h01, 3'b111}, {8'h00, 3'b000},
                             {8'h00, 3'b101}, {8'h80, 3'b011}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; cin = vc[i]; in_valid = 1'b1;
      rst = (i == 2);
      @(posedge clk); #1;
      n_total++;
      if ({s8r, co8r, ov8r, v8r} !== exp[i])
        $display("FAIL midrst_cyc%0d: got S=%h Cout=%b Ovf=%b valid=%b want %h", i, s8r,
                 co8r, ov8r, v8r, exp[i]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] ref8;
    logic [1:0] ref1;
    logic       ovf8, ovf1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); in_valid = 1'b1;
      ref8 = {1'b0, a8} + {1'b0, b8} + {8'h0, cin};
      ref1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
      ovf8 = (a8[7] == b8[7]) && (ref8[7] != a8[7]);
      ovf1 = (a1 == b1) && (ref1[0] != a1[0]);
      #1;
      n_total++;
      if ({co8c, s8c, ov8c, co1c, s1c, ov1c} !== {ref8, ovf8, ref1, ovf1})
        $display("FAIL rand_comb%0d: a8=%h b8=%h a1=%b b1=%b cin=%b got %h want %h", i, a8,
                 b8, a1, b1, cin, {co8c, s8c, ov8c, co1c, s1c, ov1c}, {ref8, ovf8, ref1, ovf1});
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({co8r, s8r, ov8r, co1r, s1r, ov1r, v8r, v1r, v8c, v1c} !==
          {ref8, ovf8, ref1, ovf1, 4'b1111})
        $display("FAIL rand_reg%0d: got %h want %h", i,
                 {co8r, s8r, ov8r, co1r, s1r, ov1r, v8r, v1r, v8c, v1c},
                 {ref8, ovf8, ref1, ovf1, 4'b1111});
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a1 = '0; b1 = '0; a8 = '0; b8 = '0; cin = 1'b0;
    test_reset();
    test_exhaustive_w1();
    test_hold();
    test_carry_w8();
    test_midstream_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
